// File: rtl/pipe_skid_register.sv
// pipe_skid_register: valid/ready pipeline stage with 2-entry skid buffer; PIPE_SKID_STALL_CNT_EN adds stall_cnt
module pipe_skid_register #(
  parameter int WIDTH = 32,
  parameter RESET_VAL = 32'h0040_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_SKID_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  input  logic             out_ready
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] main, skid, main_n, skid_n;
  logic accept, drain;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  always_comb begin
    state_n = flush ? EMPTY :
              state == EMPTY ? (accept ? ONE : EMPTY) :
              state == ONE ? ((accept & !drain) ? FULL : (!accept & drain) ? EMPTY : ONE) :
              (drain ? ONE : FULL);
    main_n = flush ? RV :
             (accept & (state == EMPTY | drain)) ? in_data :
             (state == FULL & drain) ? skid : main;
    skid_n = flush ? RV : (state == ONE & accept & !drain) ? in_data : skid;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      main  <= RV;
      skid  <= RV;
    end else begin
      state <= state_n;
      main  <= main_n;
      skid  <= skid_n;
    end
`ifdef PIPE_SKID_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (out_valid & !out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_register.sv
// tb_pipe_skid_register: scoreboard bench for pipe_skid_register
module tb_pipe_skid_register;
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [3:0] stall_cnt;
`endif
  int tests = 0, fails = 0;
  logic [31:0] q[$];
  localparam logic [31:0] RV = 32'h0040_0000;
  pipe_skid_register #(.WIDTH(32), .RESET_VAL(32'h0040_0000), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
`ifdef PIPE_SKID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_ready(out_ready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d, input logic rdy);
    in_valid = 1;
    in_data = d;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    if (rdy) q.push_back(d);
    cyc;
  endtask
  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h expected no output", out_data);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %h expected %h", out_data, e);
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    #1 rst = 0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data", out_data, RV);
    chk("rst_ready", {31'b0, in_ready}, 1);
    #10 rst = 1;
    cyc;
    out_ready = 1;
    for (int i = 1; i <= 4; i++) send(i, 1);
    in_valid = 0;
    chk("stream_valid", {31'b0, out_valid}, 1);
    cyc;
    cyc;
    chk("stream_empty", {31'b0, out_valid}, 0);
    out_ready = 0;
    send(32'hA, 1);
    send(32'hB, 1);
    chk("skid_full_ready", {31'b0, in_ready}, 0);
    chk("skid_hold_data", out_data, 32'hA);
    in_valid = 1; in_data = 32'hC;
    cyc;
    in_valid = 0;
    chk("skid_stable", out_data, 32'hA);
    out_ready = 1;
    cyc;
    chk("skid_ready_back", {31'b0, in_ready}, 1);
    chk("skid_second", out_data, 32'hB);
    cyc;
    chk("skid_empty", {31'b0, out_valid}, 0);
    out_ready = 0;
    send(32'hA2, 1);
    send(32'hB2, 1);
    in_valid = 1; in_data = 32'hC2; flush = 1;
    cyc;
    flush = 0; in_valid = 0;
    q.delete();
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_data", out_data, RV);
    chk("flush_ready", {31'b0, in_ready}, 1);
    out_ready = 1;
    cyc;
    cyc;
    chk("flush_discard", {31'b0, out_valid}, 0);
    send(32'h100, 1);
    for (int i = 1; i <= 10; i++) begin
      chk("sim_valid", {31'b0, out_valid}, 1);
      send(32'h100 + i, 1);
    end
    in_valid = 0;
    cyc;
    cyc;
    chk("sim_drained", {31'b0, out_valid}, 0);
    out_ready = 0;
    send(32'hE, 1);
    send(32'hF, 1);
    in_valid = 0;
    #3 rst = 0;
    #1;
    q.delete();
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_data", out_data, RV);
    chk("arst_ready", {31'b0, in_ready}, 1);
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("arst_cnt", {28'b0, stall_cnt}, 0);
`endif
    @(negedge clk) rst = 1;
    cyc;
`ifdef PIPE_SKID_STALL_CNT_EN
    send(32'hD, 1);
    in_valid = 0;
    chk("cnt_start", {28'b0, stall_cnt}, 0);
    repeat (5) cyc;
    chk("cnt_5", {28'b0, stall_cnt}, 5);
    repeat (15) cyc;
    chk("cnt_sat", {28'b0, stall_cnt}, 15);
    flush = 1;
    cyc;
    flush = 0;
    q.delete();
    chk("cnt_flush", {28'b0, stall_cnt}, 15);
    #3 rst = 0;
    #1;
    chk("cnt_rst", {28'b0, stall_cnt}, 0);
    @(negedge clk) rst = 1;
    cyc;
`endif
    out_ready = 1;
    repeat (3) cyc;
    chk("final_empty", {31'b0, out_valid}, 0);
    chk("sb_left", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
